add32_seq_ctrl: RTL and testbench
=================================

Name: add32_seq_ctrl

Overview:
- Multi-cycle add/subtract controller that sequences one shared 8-bit adder slice over N_SLICES cycles to produce a WIDTH-bit result.
- Slice order is LSB byte first, with the carry rippled through a register between cycles.
- Sits between the ALU issue logic (start/done handshake) and the 8-bit adder datapath.
- Trades latency for area against a full-width combinational adder.

Parameters:
- N_SLICES, 4, number of 8-bit slices; WIDTH = 8*N_SLICES; legal range 2..8.
- CNT_W, 3, width of the slice counter; must satisfy 2**CNT_W >= N_SLICES.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only when ready=1.
- sub  input  1  0: a+b+cin; 1: a-b (b inverted, cin forced to 1).
- cin  input  1  carry in; ignored when sub=1.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- ready  output  1  controller can accept start this cycle.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result valid.
- result  output  WIDTH  sum/difference; held until the next accepted start.
- carry_out  output  1  carry from the MSB slice (for sub: 1 means no borrow).
- sign  output  1  true sign of the signed result, corrected for overflow.
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, counter=0, carry reg=0.
  - Outputs after reset: ready=1, busy=0, done=0, result=0, carry_out=0, sign=0, overflow=0.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE: ready=1. On start=1:
  - latch a into opa.
  - latch b into opb, or ~b when sub=1.
  - load carry reg with sub ? 1 : cin.
  - clear counter; go to RUN.
- RUN: ready=0, busy=1. Each cycle:
  - slice inputs are opa[8k+7:8k], opb[8k+7:8k] and the carry reg, where k=counter.
  - slice sum is written into result byte k; slice carry is written into the carry reg; counter increments.
  - At k=N_SLICES-1:
    - carry_out <= slice carry.
    - overflow <= (opa msb == opb msb) && (slice sum msb != opa msb).
    - sign <= slice sum msb XOR overflow, i.e. the operands' sign on overflow, otherwise the result msb.
    - go to DONE.
  - result bytes written so far are visible mid-operation; they are only guaranteed consistent when done=1.
- DONE: done=1 for exactly one cycle; ready=1; busy=0.
  - start=1 in DONE is accepted (back-to-back): captures operands and goes directly to RUN.
  - Otherwise go to IDLE.
- Latency: start accepted at edge N; done=1 during the cycle after edge N+N_SLICES. Throughput is one operation per N_SLICES+1 cycles.
- start while busy=1 is ignored and not queued.
- Operand inputs may change freely after the accepting edge.
- Width rules:
  - slice arithmetic is 9-bit (8-bit sum plus carry).
  - for sub, carry_out=1 means a >= b unsigned.
  - all flags come from the MSB slice only.

Decomposition:
- Shared package add_pkg:
  - state enum {IDLE, RUN, DONE}.
  - SLICE_W=8 constant.
  - a helper function computing signed overflow from three msbs.
- One sub-module: the team's existing 8-bit adder slice add8, instanced once.
  - Its combinational carry_out and c are used.
  - Its flag outputs are left unconnected; the controller computes flags itself from the MSB slice.

Test Plan:
- Reset mid-RUN:
  - start a=0x0000_00FF, b=0x1, then assert rst after 2 cycles -> all outputs 0, ready=1, no done pulse.
  - Deassert rst, issue a=0x0000_00FF, b=0x1 -> result=0x0000_0100, carry_out=0, overflow=0, sign=0, done exactly 4 cycles after the accepting edge.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0, cin=1 -> result=0x0000_0000, carry_out=1, overflow=0, sign=0.
- Signed overflow positive: a=0x7FFF_FFFF, b=0x1 -> result=0x8000_0000, overflow=1, sign=0, carry_out=0.
- Signed overflow negative: a=0x8000_0000, b=0x8000_0000 -> result=0x0, carry_out=1, overflow=1, sign=1.
- Subtract with borrow: sub=1, a=0x5, b=0x7 -> result=0xFFFF_FFFE, carry_out=0, sign=1, overflow=0.
- Handshake:
  - start held high through RUN -> second operation accepted only in the DONE cycle.
  - Back-to-back done pulses are exactly 5 cycles apart.
  - Operands changed during RUN do not affect the result.

Source files
------------

// File: rtl/add_pkg.sv
`default_nettype none
// ============================================================================
// Module : add_pkg
// Brief  : Shared types and helpers for the sequenced add/subtract controller
//          and its 8-bit adder slice.
//          - state_t    : controller state encoding (IDLE, RUN, DONE)
//          - SLICE_W    : width of one adder slice
//          - signed_ovf : two's-complement overflow from operand/sum msbs
// Rev    : 1.0  initial release
// ============================================================================
package add_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Overflow occurs only when both operands share a sign and the sum does not.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/add8.sv
`default_nettype none
// ============================================================================
// Module : add8
// Brief  : Combinational 8-bit adder slice with carry in/out and flags.
// Ports  : a, b      in  8   operands
//          ci        in  1   carry in
//          c         out 8   sum
//          carry_out out 1   carry out of bit 7
//          ovf       out 1   signed overflow of this slice
//          neg       out 1   sum msb
//          zero      out 1   sum == 0
// Rev    : 1.0  initial release
// ============================================================================
module add8
  import add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] c,
  output logic               carry_out,
  output logic               ovf,
  output logic               neg,
  output logic               zero
);

  logic [SLICE_W:0] w_sum;

  // 9-bit sum: the extra bit is the slice carry.
  assign w_sum     = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};
  assign c         = w_sum[SLICE_W-1:0];
  assign carry_out = w_sum[SLICE_W];
  assign ovf       = signed_ovf(a[SLICE_W-1], b[SLICE_W-1], w_sum[SLICE_W-1]);
  assign neg       = w_sum[SLICE_W-1];
  assign zero      = (w_sum[SLICE_W-1:0] == '0);

endmodule
`default_nettype wire

// File: rtl/add32_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : add32_seq_ctrl
// Brief  : Multi-cycle add/subtract controller. One shared 8-bit slice is
//          stepped LSB byte first over N_SLICES cycles, with the carry held
//          in a register between cycles.
// Ports  : clk        in  1      rising-edge clock
//          rst        in  1      asynchronous active-high reset
//          start      in  1      request operation (taken when ready=1)
//          sub        in  1      0: a+b+cin, 1: a-b
//          cin        in  1      carry in (ignored when sub=1)
//          a, b       in  WIDTH  operands, captured on accepted start
//          ready      out 1      start can be accepted this cycle
//          busy       out 1      operation in progress
//          done       out 1      one-cycle result-valid pulse
//          result     out WIDTH  sum/difference, held until next start
//          carry_out  out 1      MSB slice carry (sub: 1 = no borrow)
//          sign       out 1      true sign of the signed result
//          overflow   out 1      signed overflow
// Rev    : 1.0  initial release
// ============================================================================
module add32_seq_ctrl
  import add_pkg::*;
#(
  parameter  int N_SLICES = 4,
  parameter  int CNT_W    = 3,
  localparam int WIDTH    = SLICE_W * N_SLICES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             sign,
  output logic             overflow
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry_out;
  logic               r_sign;
  logic               r_ovf;

  int                 w_base;
  logic [SLICE_W-1:0] w_a_slice;
  logic [SLICE_W-1:0] w_b_slice;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_co;
  logic               w_last;
  logic               w_accept;
  logic               w_msb_ovf;

  // Slice flag outputs are not needed: flags are derived below from the
  // MSB slice using the full-width operand msbs.
  logic               w_unused_ovf;
  logic               w_unused_neg;
  logic               w_unused_zero;

  assign ready     = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign sign      = r_sign;
  assign overflow  = r_ovf;

  assign w_accept  = start && ready;
  assign w_base    = SLICE_W * int'(r_cnt);
  assign w_a_slice = r_opa[w_base +: SLICE_W];
  assign w_b_slice = r_opb[w_base +: SLICE_W];
  assign w_last    = (r_cnt == CNT_W'(N_SLICES - 1));
  assign w_msb_ovf = signed_ovf(w_a_slice[SLICE_W-1], w_b_slice[SLICE_W-1],
                                w_slice_sum[SLICE_W-1]);

  add8 u_add8 (
    .a         (w_a_slice),
    .b         (w_b_slice),
    .ci        (r_carry),
    .c         (w_slice_sum),
    .carry_out (w_slice_co),
    .ovf       (w_unused_ovf),
    .neg       (w_unused_neg),
    .zero      (w_unused_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_sign      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      // Capture is shared by IDLE and DONE so back-to-back issue needs no
      // extra idle cycle.
      if (w_accept) begin
        r_opa   <= a;
        r_opb   <= sub ? ~b : b;
        r_carry <= sub ? 1'b1 : cin;
        r_cnt   <= '0;
        r_state <= ST_RUN;
      end else begin
        case (r_state)
          ST_RUN: begin
            r_result[w_base +: SLICE_W] <= w_slice_sum;
            r_carry                     <= w_slice_co;
            r_cnt                       <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_carry_out <= w_slice_co;
              r_ovf       <= w_msb_ovf;
              // On overflow the operands' sign is the true sign.
              r_sign      <= w_slice_sum[SLICE_W-1] ^ w_msb_ovf;
              r_state     <= ST_DONE;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add32_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_add32_seq_ctrl
// Brief  : Directed self-checking bench for add32_seq_ctrl (N_SLICES=4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_add32_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic        cin;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        sign;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  add32_seq_ctrl #(.N_SLICES(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .sign      (sign),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Called just after a rising edge with ready=1. Returns after the sample in
  // which done is seen; lat counts cycles from the accepting edge.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                       input logic sv, input logic cv, output int lat);
    a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; sub = ~sv; cin = ~cv;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_flags(input string tag, input logic [31:0] r,
                             input logic co, input logic ov, input logic sg);
    check({tag, ".result"},   result,        r);
    check({tag, ".carry"},    32'(carry_out), 32'(co));
    check({tag, ".overflow"}, 32'(overflow), 32'(ov));
    check({tag, ".sign"},     32'(sign),     32'(sg));
  endtask

  initial begin
    int lat;
    int lat2;
    int dones;

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.busy",  32'(busy),  32'd0);
    check("rst.done",  32'(done),  32'd0);
    check_flags("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of RUN aborts with no done pulse.
    a = 32'h0000_00FF; b = 32'h1; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("run.busy",  32'(busy),  32'd1);
    check("run.ready", 32'(ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("abort.ready", 32'(ready), 32'd1);
    check("abort.busy",  32'(busy),  32'd0);
    check("abort.done",  32'(done),  32'd0);
    check_flags("abort", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort.no_done", 32'(dones), 32'd0);

    do_op(32'h0000_00FF, 32'h1, 1'b0, 1'b0, lat);
    check("inc.latency", 32'(lat), 32'd4);
    check_flags("inc", 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("inc.done_pulse", 32'(done),  32'd0);
    check("inc.idle_ready", 32'(ready), 32'd1);
    check("inc.hold",       result,     32'h0000_0100);

    do_op(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, lat);
    check("ripple.latency", 32'(lat), 32'd4);
    check_flags("ripple", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;

    do_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    check_flags("ovf_pos", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;

    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, lat);
    check_flags("ovf_neg", 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;

    // cin=1 must be ignored when subtracting.
    do_op(32'h5, 32'h7, 1'b1, 1'b1, lat);
    check_flags("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;

    do_op(32'h0000_1234, 32'h0000_0234, 1'b1, 1'b0, lat);
    check_flags("sub_noborrow", 32'h0000_1000, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Start held high: second op only taken in the DONE cycle, and operands
    // moving during RUN do not disturb the first result.
    a = 32'h1111_1111; b = 32'h2222_2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'h0000_0010; b = 32'h0000_0020; sub = 1'b1; cin = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b.first_latency", 32'(lat), 32'd4);
    check_flags("b2b.first", 32'h3333_3333, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("b2b.accepted_busy", 32'(busy), 32'd1);
    a = 32'hFFFF_0000; b = 32'h0F0F_0F0F; sub = 1'b0;
    lat2 = 0;
    while (!done && lat2 < 20) begin
      @(posedge clk); #1;
      lat2++;
    end
    start = 1'b0;
    check("b2b.done_spacing", 32'(lat2 + 1), 32'd5);
    check_flags("b2b.second", 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("b2b.end_done",  32'(done),  32'd0);
    check("b2b.end_busy",  32'(busy),  32'd0);
    check("b2b.end_ready", 32'(ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
